// File: rtl/neuron_mac.sv
// Sequential multiply-accumulate neuron: streams N_INPUTS (x, w) pairs, adds bias,
// then saturates to signed 16 bits with optional ReLU and holds the activation until accepted.
module neuron_mac #(
    parameter int N_INPUTS = 8,
    parameter int FRAC     = 8,
    parameter int ACC_W    = 24
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] bias,
    input  logic        relu_en,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] x,
    input  logic [15:0] w,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] y,
    output logic        overflow,
    output logic        busy
);

    localparam int CNT_W = (N_INPUTS < 2) ? 1 : $clog2(N_INPUTS + 1);
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32'sd32767);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-32'sd32768);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    state_t                    state_r, state_s;
    logic signed [ACC_W-1:0]   acc_r, acc_s;
    logic [CNT_W-1:0]          cnt_r, cnt_s;
    logic                      relu_r, relu_s;
    logic [15:0]               y_r, y_s;
    logic                      overflow_r, overflow_s;
    logic                      in_ready_r, out_valid_r, busy_r;

    logic signed [31:0]        prod_s;
    logic signed [31:0]        ps_s;
    logic signed [ACC_W-1:0]   ps_ext_s;
    logic signed [ACC_W-1:0]   acc_sum_s;
    logic [16:0]               res_s;
    logic                      beat_s;

    // Clamp the wide accumulator into Q8.8, then apply ReLU; returns {overflow, y}.
    function automatic logic [16:0] sat_relu(input logic signed [ACC_W-1:0] a,
                                             input logic relu);
        logic [15:0] v;
        logic        o;
        if (a > SAT_MAX) begin
            v = 16'h7FFF;
            o = 1'b1;
        end else if (a < SAT_MIN) begin
            v = 16'h8000;
            o = 1'b1;
        end else begin
            v = a[15:0];
            o = 1'b0;
        end
        if (relu && v[15]) begin
            v = 16'h0000;
        end else begin
            v = v;
        end
        return {o, v};
    endfunction

    assign prod_s    = $signed(x) * $signed(w);
    assign ps_s      = prod_s >>> FRAC;
    assign ps_ext_s  = ACC_W'(ps_s);
    assign acc_sum_s = acc_r + ps_ext_s;
    assign res_s     = sat_relu(acc_sum_s, relu_r);
    assign beat_s    = in_valid && (state_r == ST_ACC);

    // Next-state and datapath update for the IDLE/ACC/OUT sequence.
    always_comb begin
        state_s    = state_r;
        acc_s      = acc_r;
        cnt_s      = cnt_r;
        relu_s     = relu_r;
        y_s        = y_r;
        overflow_s = overflow_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s = ST_ACC;
                    acc_s   = ACC_W'($signed(bias));
                    cnt_s   = {CNT_W{1'b0}};
                    relu_s  = relu_en;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ACC: begin
                if (beat_s) begin
                    acc_s = acc_sum_s;
                    cnt_s = cnt_r + CNT_W'(1);
                    if (cnt_r == CNT_W'(N_INPUTS - 1)) begin
                        state_s    = ST_OUT;
                        y_s        = res_s[15:0];
                        overflow_s = res_s[16];
                    end else begin
                        state_s = ST_ACC;
                    end
                end else begin
                    state_s = ST_ACC;
                end
            end
            ST_OUT: begin
                if (out_ready) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_OUT;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, datapath and handshake registers; handshake flags follow the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            acc_r       <= {ACC_W{1'b0}};
            cnt_r       <= {CNT_W{1'b0}};
            relu_r      <= 1'b0;
            y_r         <= 16'h0000;
            overflow_r  <= 1'b0;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            acc_r       <= acc_s;
            cnt_r       <= cnt_s;
            relu_r      <= relu_s;
            y_r         <= y_s;
            overflow_r  <= overflow_s;
            in_ready_r  <= (state_s == ST_ACC);
            out_valid_r <= (state_s == ST_OUT);
            busy_r      <= (state_s != ST_IDLE);
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign y         = y_r;
    assign overflow  = overflow_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_neuron_mac.sv
// Directed self-checking bench for neuron_mac with N_INPUTS=4; inputs driven and
// outputs sampled on the falling clock edge.
module tb_neuron_mac;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] bias;
    logic        relu_en;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] x;
    logic [15:0] w;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] y;
    logic        overflow;
    logic        busy;

    int errors = 0;
    int checks = 0;

    // 32-bit accumulator keeps four full-scale products from wrapping, so the
    // saturation vectors exercise the clamp rather than the wrap.
    neuron_mac #(.N_INPUTS(4), .FRAC(8), .ACC_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .bias      (bias),
        .relu_en   (relu_en),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .w         (w),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .overflow  (overflow),
        .busy      (busy)
    );

    // 10 ns clock.
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One full operation: start, four beats (optional 2-cycle stall before beat stall_at),
    // then hold out_ready low for 'hold' cycles before accepting the result.
    task automatic run_op(input string tag, input logic [15:0] b, input logic r,
                          input logic [3:0][15:0] xs, input logic [3:0][15:0] ws,
                          input int stall_at, input int hold,
                          input logic [15:0] exp_y, input logic exp_o);
        int n;
        int exp_lat;
        @(negedge clk);
        start = 1'b1; bias = b; relu_en = r;
        in_valid = 1'b1; x = 16'h7F00; w = 16'h7F00;
        n = 0;
        @(negedge clk);
        n++;
        start = 1'b0; bias = ~b; relu_en = ~r; in_valid = 1'b0;
        check({tag, "_busy"}, 32'(busy), 32'd1);
        for (int i = 0; i < 4; i++) begin
            if (i == stall_at) begin
                for (int s = 0; s < 2; s++) begin
                    in_valid = 1'b0; x = 16'h4000; w = 16'h4000; start = 1'b1;
                    @(negedge clk);
                    n++;
                end
                start = 1'b0;
            end
            check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
            in_valid = 1'b1; x = xs[i]; w = ws[i];
            @(negedge clk);
            n++;
        end
        in_valid = 1'b0; x = 16'h0000; w = 16'h0000;
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        exp_lat = (stall_at >= 0) ? 7 : 5;
        check({tag, "_latency"}, 32'(n), 32'(exp_lat));
        check({tag, "_y"}, 32'(y), 32'(exp_y));
        check({tag, "_overflow"}, 32'(overflow), 32'(exp_o));
        check({tag, "_out_in_ready"}, 32'(in_ready), 32'd0);
        for (int h = 0; h < hold; h++) begin
            out_ready = 1'b0; start = 1'b1; in_valid = 1'b1; x = 16'h1234; w = 16'h0100;
            @(negedge clk);
            check({tag, "_hold_y"}, 32'(y), 32'(exp_y));
            check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
            check({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
        end
        start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_idle_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_idle_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; bias = 16'h0000; relu_en = 1'b0;
        in_valid = 1'b0; x = 16'h0000; w = 16'h0000; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_y", 32'(y), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);

        // 1.0 + 2.0 - 1.0 + 0.5 + bias 0.5 = 3.0
        run_op("basic", 16'h0080, 1'b0, {16'h0080, 16'hFF00, 16'h0200, 16'h0100},
               {4{16'h0100}}, -1, 0, 16'h0300, 1'b0);
        run_op("basic_relu", 16'h0080, 1'b1, {16'h0080, 16'hFF00, 16'h0200, 16'h0100},
               {4{16'h0100}}, -1, 0, 16'h0300, 1'b0);
        run_op("relu_on", 16'hF000, 1'b1, {4{16'h0000}}, {4{16'h0100}}, -1, 0, 16'h0000, 1'b0);
        run_op("relu_off", 16'hF000, 1'b0, {4{16'h0000}}, {4{16'h0100}}, -1, 0, 16'hF000, 1'b0);
        run_op("sat_pos", 16'h0000, 1'b0, {4{16'h7F00}}, {4{16'h7F00}}, -1, 0, 16'h7FFF, 1'b1);
        run_op("sat_neg", 16'h0000, 1'b0, {4{16'h7F00}}, {4{16'h8100}}, -1, 0, 16'h8000, 1'b1);
        run_op("sat_neg_relu", 16'h0000, 1'b1, {4{16'h7F00}}, {4{16'h8100}}, -1, 0, 16'h0000, 1'b1);
        run_op("edge_max", 16'h7FFF, 1'b0, {4{16'h0000}}, {4{16'h0100}}, -1, 0, 16'h7FFF, 1'b0);
        run_op("edge_max1", 16'h7FFF, 1'b0, {16'h0000, 16'h0000, 16'h0000, 16'h0001},
               {4{16'h0100}}, -1, 0, 16'h7FFF, 1'b1);
        run_op("edge_min1", 16'h8000, 1'b0, {16'h0000, 16'h0000, 16'h0000, 16'hFFFF},
               {4{16'h0100}}, -1, 0, 16'h8000, 1'b1);
        run_op("stall", 16'h0080, 1'b0, {16'h0080, 16'hFF00, 16'h0200, 16'h0100},
               {4{16'h0100}}, 2, 3, 16'h0300, 1'b0);

        // Abort after two accepted beats.
        @(negedge clk);
        start = 1'b1; bias = 16'h0080; relu_en = 1'b0;
        @(negedge clk);
        start = 1'b0; in_valid = 1'b1; x = 16'h0100; w = 16'h0100;
        @(negedge clk);
        x = 16'h0200;
        @(negedge clk);
        in_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_in_ready", 32'(in_ready), 32'd0);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_y", 32'(y), 32'd0);
        check("abort_overflow", 32'(overflow), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        run_op("after_abort", 16'h0080, 1'b0, {16'h0080, 16'hFF00, 16'h0200, 16'h0100},
               {4{16'h0100}}, -1, 0, 16'h0300, 1'b0);

        run_op("trunc", 16'h0000, 1'b0, {4{16'hFFFF}}, {4{16'h0001}}, -1, 0, 16'hFFFC, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/neuron_mac.md
# neuron_mac

Sequential multiply-accumulate neuron stage that sits directly upstream of the ALU result path in the autoencoder datapath. It accepts a stream of N_INPUTS signed Q8.8 (input, weight) pairs over a valid/ready handshake. It accumulates their products plus a bias in a widened accumulator, then saturates to 16 bits and optionally applies ReLU. It presents one neuron activation per operation on an output valid/ready handshake, ready for the next layer or for ALU post-processing.

## Interface
- N_INPUTS, 8, number of (x, w) pairs per neuron; ≥1
- FRAC, 8, fractional bits of the signed fixed-point format (Q(16-FRAC).FRAC)
- ACC_W, 24, accumulator width in bits; ≥17
- clk  input  1  single clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  begins a neuron operation; sampled only in IDLE
- bias  input  16  signed Q8.8 bias; latched on accepted start
- relu_en  input  1  latched on accepted start; 1 = clamp negative results to 0
- in_valid  input  1  x/w pair valid
- in_ready  output  1  stage accepts a pair this cycle
- x  input  16  signed input activation
- w  input  16  signed weight
- out_valid  output  1  y valid, held until accepted
- out_ready  input  1  downstream accepts y
- y  output  16  signed Q8.8 activation
- overflow  output  1  saturation occurred for the current y; valid with out_valid
- busy  output  1  high in every state except IDLE

## Operation
- FSM states: IDLE, ACC, OUT.
- IDLE: in_ready=0, out_valid=0, busy=0. On start=1: acc ← sign-extend(bias) to ACC_W, cnt ← 0, latch relu_en, go to ACC.
- ACC: in_ready=1, busy=1. A beat is accepted when in_valid & in_ready.
  - Per beat: p = signed(x)·signed(w), 32 bits; ps = p >>> FRAC (arithmetic shift, truncation toward −∞); acc ← acc + sign-extend/truncate(ps) to ACC_W.
  - The ACC_W addition wraps. No saturation occurs inside the accumulator.
  - cnt increments per beat. The beat that makes cnt = N_INPUTS moves the FSM to OUT and loads y/overflow in the same edge.
- Output formation from the final acc value:
  - If acc > 32767: y=0x7FFF, overflow=1.
  - If acc < −32768: y=0x8000, overflow=1.
  - Otherwise y=acc[15:0], overflow=0.
  - ReLU is applied after saturation. If relu_en and y negative: y=0x0000, and overflow keeps its saturation value.
- OUT: out_valid=1, in_ready=0. y and overflow stay stable until out_valid & out_ready, then return to IDLE.
- start outside IDLE is ignored. in_valid outside ACC is ignored; no beat is consumed.
- bias and relu_en changes after start have no effect on the current operation.

## Timing
- Reset values: in_ready=0, out_valid=0, y=0x0000, overflow=0, busy=0. FSM=IDLE, acc=0, cnt=0.
- Reset mid-operation (ACC or OUT) aborts the operation. The next cycle is IDLE with all outputs at reset values, and partial sums are discarded.
- start at edge t: in_ready=1 from cycle t+1.
- Throughput is one beat per cycle in ACC. in_valid stalls insert bubbles with no penalty.
- Last beat accepted at edge t: out_valid=1 and y valid in cycle t+1. Minimum latency from start to out_valid is N_INPUTS+1 cycles.
- Output accepted at edge t: IDLE in cycle t+1. A start asserted in cycle t+1 is accepted, so there is one idle cycle between operations.
- in_ready is a registered function of FSM state only and never depends combinationally on in_valid. out_valid does not depend on out_ready.

## Test plan
- Basic sum: N_INPUTS=4, bias=0x0080, relu_en=0, x={0x0100,0x0200,0xFF00,0x0080}, w=0x0100 each, back-to-back → out_valid 5 cycles after start, y=0x0300, overflow=0.
- ReLU: bias=0xF000, all x=0, relu_en=1 → y=0x0000, overflow=0. Repeat with relu_en=0 → y=0xF000.
- Saturation: x=w=0x7F00 for all 4 beats, bias=0 → y=0x7FFF, overflow=1. x=0x7F00, w=0x8100, relu_en=0 → y=0x8000, overflow=1. Same with relu_en=1 → y=0x0000, overflow=1.
- Handshake stalls: drop in_valid for 2 cycles between beats 2 and 3, hold out_ready=0 for 3 cycles → result identical to the basic-sum case (0x0300). y is stable while stalled, in_ready=0 in OUT, and start pulses during ACC/OUT are ignored.
- Reset mid-op: assert rst after 2 accepted beats → next cycle all outputs at reset values. A fresh basic-sum run then yields 0x0300 with no residue from the aborted sums.
- Truncation: x=0xFFFF, w=0x0001, N_INPUTS=4, bias=0 → each ps=−1, y=0xFFFC.
